// File: rtl/disp_pkg.sv
// Shared types and constants for the serial dot-matrix display driver.
// Holds the controller state encoding and the control-word field layout.
package disp_pkg;

  typedef enum logic [2:0] {HOLD, SETUP, C1, C0, DOTS, LATCH, IDLE} state_t;

  localparam int CHAR_DOTS = 40;

  // Bit 7 selects the control word; the remaining fields depend on which word it is.
  localparam int CW_SELECT_BIT  = 7;
  localparam int CW0_SLEEP_BIT  = 6;
  localparam int CW0_PEAK_LSB   = 4;
  localparam int CW0_PEAK_W     = 2;
  localparam int CW0_BRIGHT_LSB = 0;
  localparam int CW0_BRIGHT_W   = 4;
  localparam int CW1_DOUT_BIT   = 0;

  function automatic logic [7:0] ctrl0_word(input logic normal, input logic [1:0] peak,
                                            input logic [3:0] bright);
    return {1'b0, normal, peak, bright};
  endfunction

  function automatic logic [7:0] ctrl1_word(input logic simultaneous);
    return {1'b1, 6'b000000, simultaneous};
  endfunction

endpackage

// File: rtl/disp_bit_timer.sv
// Serial bit timer: counts CLK_DIV clocks per phase and flags the end of the
// low phase (clock rises) and the end of the high phase (bit complete).
module disp_bit_timer
  #(parameter int CLK_DIV = 25)
  (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic shift,
    output logic tick,
    output logic rise,
    output logic bit_done
  );

  localparam int DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0] div_cnt;
  logic          phase;

  assign tick     = run && (div_cnt == DW'(CLK_DIV - 1));
  assign rise     = tick && shift && !phase;
  assign bit_done = tick && shift && phase;

  // Without shift the timer only measures a plain CLK_DIV hold; phase stays low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      if (shift) phase <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dot_display_driver.sv
// Serial controller for a chain of 4-character 5x7 dot-matrix displays:
// initialises the chain with two control words, then shifts and latches dot frames.
module dot_display_driver
  import disp_pkg::*;
  #(
    parameter int          NUM_CHARS  = 16,
    parameter int          CLK_DIV    = 25,
    parameter int          RESET_HOLD = 64,
    parameter logic [7:0]  CTRL0      = ctrl0_word(1'b1, 2'b11, 4'hF),
    parameter logic [7:0]  CTRL1      = ctrl1_word(1'b1)
  )
  (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHAR_DOTS*NUM_CHARS-1:0] dots,
    input  logic                          update,
    output logic                          busy,
    output logic                          disp_clock,
    output logic                          disp_data_out,
    output logic                          disp_rs,
    output logic                          disp_ce_b,
    output logic                          disp_reset_b,
    output logic                          disp_blank,
    output state_t                        dbg_state
  );

  localparam int FW      = CHAR_DOTS * NUM_CHARS;
  localparam int BW      = $clog2(FW + 1);
  localparam int HW      = $clog2(RESET_HOLD + 1);
  localparam int C1_BITS = 2 * NUM_CHARS;

  // Control words are left-aligned so every word leaves the shift register MSB first.
  localparam logic [FW-1:0] C1_FRAME = FW'({(NUM_CHARS/4){CTRL1}}) << (FW - C1_BITS);
  localparam logic [FW-1:0] C0_FRAME = FW'(CTRL0) << (FW - 8);

  state_t        state, state_n, src, src_n;
  logic [FW-1:0] sr, sr_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n, last_idx;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          pending, pending_n;
  logic          clock_n, data_n, rs_n, ce_b_n, reset_b_n, blank_n;
  logic          run, shift, tick, rise, bit_done;

  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign shift     = (state == C1) || (state == C0) || (state == DOTS);
  // LATCH spends its first cycle raising ce_b, then times the CLK_DIV hold.
  assign run       = (state == SETUP) || shift || ((state == LATCH) && disp_ce_b);

  disp_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .shift    (shift),
    .tick     (tick),
    .rise     (rise),
    .bit_done (bit_done)
  );

  always_comb begin
    case (state)
      C1:      last_idx = BW'(C1_BITS - 1);
      C0:      last_idx = BW'(7);
      default: last_idx = BW'(FW - 1);
    endcase
  end

  always_comb begin
    state_n    = state;
    src_n      = src;
    sr_n       = sr;
    bit_cnt_n  = bit_cnt;
    hold_cnt_n = hold_cnt;
    pending_n  = pending || (update && (state != IDLE));
    clock_n    = disp_clock;
    data_n     = disp_data_out;
    rs_n       = disp_rs;
    ce_b_n     = disp_ce_b;
    reset_b_n  = disp_reset_b;
    blank_n    = disp_blank;
    case (state)
      HOLD: begin
        if (hold_cnt == HW'(RESET_HOLD - 1)) begin
          reset_b_n = 1'b1;
          ce_b_n    = 1'b0;
          rs_n      = 1'b1;
          sr_n      = C1_FRAME;
          src_n     = C1;
          state_n   = SETUP;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      SETUP: begin
        if (tick) begin
          state_n   = src;
          data_n    = sr[FW-1];
          sr_n      = sr << 1;
          bit_cnt_n = '0;
        end
      end
      C1, C0, DOTS: begin
        if (rise) clock_n = 1'b1;
        if (bit_done) begin
          clock_n = 1'b0;
          if (bit_cnt == last_idx) begin
            state_n = LATCH;
          end else begin
            data_n    = sr[FW-1];
            sr_n      = sr << 1;
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      LATCH: begin
        if (!disp_ce_b) begin
          ce_b_n = 1'b1;
        end else if (tick) begin
          if (src == C1) begin
            ce_b_n  = 1'b0;
            rs_n    = 1'b1;
            sr_n    = C0_FRAME;
            src_n   = C0;
            state_n = SETUP;
          end else begin
            if (src == C0) blank_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      IDLE: begin
        if (update || pending) begin
          sr_n      = dots;
          pending_n = 1'b0;
          ce_b_n    = 1'b0;
          rs_n      = 1'b0;
          src_n     = DOTS;
          state_n   = SETUP;
        end
      end
      default: state_n = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HOLD;
      src           <= C1;
      sr            <= '0;
      bit_cnt       <= '0;
      hold_cnt      <= '0;
      pending       <= 1'b0;
      disp_clock    <= 1'b0;
      disp_data_out <= 1'b0;
      disp_rs       <= 1'b0;
      disp_ce_b     <= 1'b1;
      disp_reset_b  <= 1'b0;
      disp_blank    <= 1'b1;
    end else begin
      state         <= state_n;
      src           <= src_n;
      sr            <= sr_n;
      bit_cnt       <= bit_cnt_n;
      hold_cnt      <= hold_cnt_n;
      pending       <= pending_n;
      disp_clock    <= clock_n;
      disp_data_out <= data_n;
      disp_rs       <= rs_n;
      disp_ce_b     <= ce_b_n;
      disp_reset_b  <= reset_b_n;
      disp_blank    <= blank_n;
    end
  end

endmodule

// File: tb/tb_dot_display_driver.sv
// Bench for dot_display_driver: a 4-character chain (CLK_DIV=2) and a 16-character
// chain (CLK_DIV=1), with pin-level capture of every shifted bit and latch.
module tb_dot_display_driver;
  import disp_pkg::*;

  localparam int FW_A = 160;
  localparam int FW_B = 640;
  localparam int DIV_A = 2;
  localparam int DIV_B = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, update, b_reset_n, b_update;
  logic [FW_A-1:0] dots;
  logic [FW_B-1:0] b_dots;
  logic busy, disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b, disp_blank;
  logic b_busy, b_clock, b_data, b_rs, b_ce_b, b_reset_b, b_blank;
  state_t dbg_state, b_dbg_state;

  dot_display_driver #(.NUM_CHARS(4), .CLK_DIV(DIV_A), .RESET_HOLD(8)) dut (
    .clk(clk), .reset_n(reset_n), .dots(dots), .update(update), .busy(busy),
    .disp_clock(disp_clock), .disp_data_out(disp_data_out), .disp_rs(disp_rs),
    .disp_ce_b(disp_ce_b), .disp_reset_b(disp_reset_b), .disp_blank(disp_blank),
    .dbg_state(dbg_state)
  );

  dot_display_driver #(.NUM_CHARS(16), .CLK_DIV(DIV_B), .RESET_HOLD(8)) dut_b (
    .clk(clk), .reset_n(b_reset_n), .dots(b_dots), .update(b_update), .busy(b_busy),
    .disp_clock(b_clock), .disp_data_out(b_data), .disp_rs(b_rs),
    .disp_ce_b(b_ce_b), .disp_reset_b(b_reset_b), .disp_blank(b_blank),
    .dbg_state(b_dbg_state)
  );

  // ---------------- pin monitors ----------------
  logic [1:0] a_cap_q[$];
  logic [1:0] b_cap_q[$];
  int   a_latch_cnt = 0, b_latch_cnt = 0;
  logic a_prev_clk = 1'b0, a_prev_ce = 1'b1, b_prev_clk = 1'b0, b_prev_ce = 1'b1;

  always @(negedge clk) begin
    if (reset_n && !a_prev_clk && disp_clock) a_cap_q.push_back({disp_rs, disp_data_out});
    if (reset_n && !a_prev_ce && disp_ce_b) a_latch_cnt++;
    a_prev_clk = disp_clock;
    a_prev_ce  = disp_ce_b;
  end

  always @(negedge clk) begin
    if (b_reset_n && !b_prev_clk && b_clock) b_cap_q.push_back({b_rs, b_data});
    if (b_reset_n && !b_prev_ce && b_ce_b) b_latch_cnt++;
    b_prev_clk = b_clock;
    b_prev_ce  = b_ce_b;
  end

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bits(input logic rs, input logic [FW_B-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({rs, v[i]});
  endtask

  task automatic compare_bits(input string name, input logic [1:0] cap[$]);
    int bad = 0;
    check({name, " bit count"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) bad++;
    check({name, " bit errors"}, 64'(bad), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_latch(input int sel, input int target, input string name);
    int n = 0;
    while (((sel == 0) ? a_latch_cnt : b_latch_cnt) < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({name, " latch seen"}, 64'((sel == 0) ? a_latch_cnt : b_latch_cnt), 64'(target));
  endtask

  task automatic wait_idle(input int sel, input string name);
    int n = 0;
    while (((sel == 0) ? busy : b_busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, " busy fell"}, 64'((sel == 0) ? busy : b_busy), 64'd0);
  endtask

  task automatic pulse_update(input logic [FW_A-1:0] d);
    @(negedge clk);
    dots   = d;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  // Counts negedges with busy high after the request; returns at the first idle sample.
  task automatic run_frame(input logic [FW_A-1:0] d, output int cycles);
    pulse_update(d);
    cycles = 0;
    while (busy && cycles < 5000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic release_and_init_a(input string name);
    int n = 0;
    int base;
    base = a_latch_cnt;
    @(negedge clk);
    reset_n = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (disp_reset_b) break;
    end
    check({name, " reset hold clks"}, 64'(n), 64'd8);
    push_bits(1'b1, FW_B'(8'h81), 8);
    wait_latch(0, base + 1, {name, " ctrl1"});
    compare_bits({name, " ctrl1"}, a_cap_q);
    a_cap_q.delete();
    push_bits(1'b1, FW_B'(8'h7F), 8);
    wait_latch(0, base + 2, {name, " ctrl0"});
    compare_bits({name, " ctrl0"}, a_cap_q);
    a_cap_q.delete();
    wait_idle(0, name);
    check({name, " blank"}, 64'(disp_blank), 64'd0);
  endtask

  typedef struct {
    logic [FW_A-1:0] dots;
    int              ones;
    logic            first;
    logic            last;
  } vec_t;

  vec_t vecs[5];
  // SETUP hold, two phases per bit, one cycle to raise ce_b, then the ce_b hold.
  localparam int FRAME_A = DIV_A + 2 * DIV_A * FW_A + 1 + DIV_A;
  localparam int FRAME_B = DIV_B + 2 * DIV_B * FW_B + 1 + DIV_B;

  initial begin
    int cyc, base, ones;
    logic [FW_A-1:0] d1, d2, d3;
    logic [FW_B-1:0] bd;

    vecs[0] = '{dots: {1'b1, 158'b0, 1'b1}, ones: 2,   first: 1'b1, last: 1'b1};
    vecs[1] = '{dots: '0,                   ones: 0,   first: 1'b0, last: 1'b0};
    vecs[2] = '{dots: '1,                   ones: 160, first: 1'b1, last: 1'b1};
    vecs[3] = '{dots: {20{8'hA5}},          ones: 80,  first: 1'b1, last: 1'b1};
    vecs[4] = '{dots: {40{4'h3}},           ones: 80,  first: 1'b0, last: 1'b1};

    reset_n = 1'b0; b_reset_n = 1'b0; update = 1'b0; b_update = 1'b0;
    dots = '0; b_dots = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd1);
    check("rst state", 64'(dbg_state), 64'(HOLD));
    check("rst reset_b", 64'(disp_reset_b), 64'd0);
    check("rst ce_b", 64'(disp_ce_b), 64'd1);
    check("rst rs", 64'(disp_rs), 64'd0);
    check("rst clock", 64'(disp_clock), 64'd0);
    check("rst data", 64'(disp_data_out), 64'd0);
    check("rst blank", 64'(disp_blank), 64'd1);

    release_and_init_a("init");

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      base = a_latch_cnt;
      run_frame(vecs[v].dots, cyc);
      check($sformatf("vec%0d busy clks", v), 64'(cyc), 64'(FRAME_A));
      check($sformatf("vec%0d latches", v), 64'(a_latch_cnt), 64'(base + 1));
      ones = 0;
      foreach (a_cap_q[i]) if (a_cap_q[i][0]) ones++;
      check($sformatf("vec%0d ones", v), 64'(ones), 64'(vecs[v].ones));
      if (a_cap_q.size() > 0) begin
        check($sformatf("vec%0d first", v), 64'(a_cap_q[0][0]), 64'(vecs[v].first));
        check($sformatf("vec%0d last", v), 64'(a_cap_q[a_cap_q.size()-1][0]), 64'(vecs[v].last));
      end
      push_bits(1'b0, FW_B'(vecs[v].dots), FW_A);
      compare_bits($sformatf("vec%0d", v), a_cap_q);
      a_cap_q.delete();
    end

    // dots changes mid-DOTS must not reach the frame in flight
    d1 = {40{4'hC}};
    d2 = {40{4'h5}};
    base = a_latch_cnt;
    pulse_update(d1);
    repeat (200) @(negedge clk);
    dots = d2;
    wait_latch(0, base + 1, "snapshot");
    wait_idle(0, "snapshot");
    push_bits(1'b0, FW_B'(d1), FW_A);
    compare_bits("snapshot", a_cap_q);
    a_cap_q.delete();

    // Three requests while busy collapse into one frame carrying the latest dots
    d1 = {10{16'h0F0F}};
    d3 = {16{10'h2B3}};
    base = a_latch_cnt;
    pulse_update(d1);
    repeat (100) @(negedge clk);
    pulse_update({160{1'b1}});
    repeat (50) @(negedge clk);
    pulse_update({80{2'b10}});
    repeat (50) @(negedge clk);
    pulse_update(d3);
    wait_latch(0, base + 1, "multi first");
    push_bits(1'b0, FW_B'(d1), FW_A);
    compare_bits("multi first", a_cap_q);
    a_cap_q.delete();
    wait_latch(0, base + 2, "multi second");
    push_bits(1'b0, FW_B'(d3), FW_A);
    compare_bits("multi second", a_cap_q);
    a_cap_q.delete();
    wait_idle(0, "multi");
    repeat (50) @(negedge clk);
    check("multi no extra frame", 64'(a_latch_cnt), 64'(base + 2));
    check("multi idle", 64'(busy), 64'd0);

    // Reset halfway through DOTS
    base = a_latch_cnt;
    pulse_update({160{1'b1}});
    repeat (320) @(negedge clk);
    check("mid reset in dots", 64'(dbg_state), 64'(DOTS));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid reset state", 64'(dbg_state), 64'(HOLD));
    check("mid reset ce_b", 64'(disp_ce_b), 64'd1);
    check("mid reset clock", 64'(disp_clock), 64'd0);
    check("mid reset data", 64'(disp_data_out), 64'd0);
    check("mid reset reset_b", 64'(disp_reset_b), 64'd0);
    check("mid reset blank", 64'(disp_blank), 64'd1);
    check("mid reset busy", 64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    check("mid reset no latch", 64'(a_latch_cnt), 64'(base));
    a_cap_q.delete();
    release_and_init_a("reinit");
    run_frame(vecs[0].dots, cyc);
    check("reinit frame busy clks", 64'(cyc), 64'(FRAME_A));
    push_bits(1'b0, FW_B'(vecs[0].dots), FW_A);
    compare_bits("reinit frame", a_cap_q);
    a_cap_q.delete();

    // 16-character chain, CLK_DIV=1
    @(negedge clk);
    b_reset_n = 1'b1;
    bd = '0;
    bd[31:0] = {4{8'h81}};
    push_bits(1'b1, bd, 32);
    wait_latch(1, 1, "b ctrl1");
    compare_bits("b ctrl1", b_cap_q);
    b_cap_q.delete();
    push_bits(1'b1, FW_B'(8'h7F), 8);
    wait_latch(1, 2, "b ctrl0");
    compare_bits("b ctrl0", b_cap_q);
    b_cap_q.delete();
    wait_idle(1, "b init");
    check("b blank", 64'(b_blank), 64'd0);
    bd = {16{40'h80_0000_0001}};
    @(negedge clk);
    b_dots = bd;
    b_update = 1'b1;
    @(negedge clk);
    b_update = 1'b0;
    cyc = 0;
    while (b_busy && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    check("b frame busy clks", 64'(cyc), 64'(FRAME_B));
    ones = 0;
    foreach (b_cap_q[i]) if (b_cap_q[i][0]) ones++;
    check("b frame ones", 64'(ones), 64'd32);
    push_bits(1'b0, bd, FW_B);
    compare_bits("b frame", b_cap_q);
    b_cap_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
